spi_slave: RTL

// SPI responder (slave) core, the counterpart of the SPI master in devices/spi. It lets an FPGA SoC act as an
// SPI peripheral to an external controller. sck/ss_n/mosi are oversampled in the clk domain, bytes are

---
 rtl/spi_slave.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI responder core: oversamples sck/ss_n/mosi in the clk domain and shifts words per CPOL/CPHA/LSBFE,
// with a one-entry TX holding register and an RX strobe as the host handshake.
module spi_slave #(
    parameter int                   DATA_BITS   = 8,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [DATA_BITS-1:0] FILL_WORD   = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 lsbfe,
    input  logic                 sck,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 tx_underrun,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_d, ss_d;
    logic                   sck_q, ss_q, mosi_q;
    logic                   cpol_l, cpha_l, lsbfe_l;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   tx_sr, rx_sr, rx_word_nx, hold_data;
    logic                   hold_full;
    logic                   ss_fall, ss_rise, sck_edge, lead, trail;
    logic                   start, sample_edge, shift_edge, load, shift_out, word_done, capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_q;
            ss_d      <= ss_q;
        end
    end

    assign sck_q  = sck_sync[SYNC_STAGES-1];
    assign ss_q   = ss_sync[SYNC_STAGES-1];
    assign mosi_q = mosi_sync[SYNC_STAGES-1];

    // Leading edge moves sck away from the latched idle level; ss_n rising outranks any sck edge.
    assign ss_fall     = ss_d & ~ss_q;
    assign ss_rise     = ~ss_d & ss_q;
    assign sck_edge    = sck_q ^ sck_d;
    assign lead        = sck_edge & (sck_q ^ cpol_l);
    assign trail       = sck_edge & ~(sck_q ^ cpol_l);
    assign start       = (state == IDLE) & ss_fall;
    assign sample_edge = (state == ACTIVE) & ~ss_rise & (cpha_l ? trail : lead);
    assign shift_edge  = (state == ACTIVE) & ~ss_rise & (cpha_l ? lead : trail);
    assign load        = (start & ~cpha) | (shift_edge & (bit_cnt == '0));
    assign shift_out   = shift_edge & (bit_cnt != '0);
    assign word_done   = sample_edge & (bit_cnt == CNT_W'(DATA_BITS - 1));
    assign capture     = tx_valid & ~hold_full;
    assign rx_word_nx  = lsbfe_l ? {mosi_q, rx_sr[DATA_BITS-1:1]}
                                 : {rx_sr[DATA_BITS-2:0], mosi_q};
    assign tx_ready    = ~hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (ss_fall) state_nx = ACTIVE;
            ACTIVE: if (ss_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        miso_oe = 1'b0;
        miso    = 1'b0;
        if (state == ACTIVE) begin
            miso_oe = 1'b1;
            miso    = lsbfe_l ? tx_sr[0] : tx_sr[DATA_BITS-1];
        end
        busy = ~ss_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_l    <= 1'b0;
            cpha_l    <= 1'b0;
            lsbfe_l   <= 1'b0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                cpol_l  <= cpol;
                cpha_l  <= cpha;
                lsbfe_l <= lsbfe;
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if ((state == ACTIVE) && ss_rise) begin
                frame_err <= (bit_cnt != '0);
                bit_cnt   <= '0;
                rx_sr     <= '0;
            end else if (sample_edge) begin
                rx_sr   <= rx_word_nx;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
                if (word_done) begin
                    rx_data  <= rx_word_nx;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    // A same-cycle capture and LOAD: the LOAD sees the old (empty) state, the new word still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr       <= '0;
            tx_underrun <= 1'b0;
            hold_full   <= 1'b0;
            hold_data   <= '0;
        end else begin
            tx_underrun <= 1'b0;
            if (load) begin
                tx_sr       <= hold_full ? hold_data : FILL_WORD;
                tx_underrun <= ~hold_full;
            end else if (shift_out) begin
                tx_sr <= lsbfe_l ? (tx_sr >> 1) : (tx_sr << 1);
            end
            if (capture) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule
